// File: rtl/lcs_frame_serializer.sv
// Frame serializer for the LCS answer stage: walks word addresses, handshakes
// req/ack with the answer stage and shifts each returned byte out UART-style.
module lcs_frame_serializer #(
   parameter int FRAME_LEN   = 256,
   parameter int CLK_DIV     = 16,
   parameter int ACK_TIMEOUT = 1023
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       edge_tx,
   output logic [8:0] addr_lcs,
   output logic       req,
   input  logic       ack,
   input  logic [7:0] data_in,
   output logic       txd,
   output logic       busy,
   output logic       frame_done,
   output logic       timeout_err
);

   localparam int DivW = $clog2(CLK_DIV);
   localparam int ToW  = $clog2(ACK_TIMEOUT + 1);
   localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
   localparam logic [DivW-1:0] DivHalf  = DivW'(CLK_DIV / 2);
   localparam logic [ToW-1:0]  ToLast   = ToW'(ACK_TIMEOUT - 1);
   localparam logic [8:0]      AddrLast = 9'(FRAME_LEN - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_REL, SEND, NEXT} stateT;

   stateT          state, stateNext;
   logic [DivW-1:0] divCnt;
   logic           tick;
   logic           ackMeta, ackS;
   logic [ToW-1:0] toCnt, toNext;
   logic [7:0]     shiftReg, shiftNext;
   logic [3:0]     bitCnt, bitNext;
   logic           sending, sendingNext;
   logic [8:0]     addrNext;
   logic           reqNext, txdNext, busyNext, doneNext, errNext;

   assign tick = (divCnt == DivLast);

   // Free-running bit-rate divider; also the clock the answer stage runs on.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         divCnt  <= '0;
         edge_tx <= 1'b0;
         ackMeta <= 1'b0;
         ackS    <= 1'b0;
      end else begin
         divCnt  <= tick ? '0 : divCnt + 1'b1;
         edge_tx <= (divCnt >= DivHalf);
         ackMeta <= ack;
         ackS    <= ackMeta;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         addr_lcs    <= '0;
         req         <= 1'b0;
         txd         <= 1'b1;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         timeout_err <= 1'b0;
         toCnt       <= '0;
         shiftReg    <= '0;
         bitCnt      <= '0;
         sending     <= 1'b0;
      end else begin
         state       <= stateNext;
         addr_lcs    <= addrNext;
         req         <= reqNext;
         txd         <= txdNext;
         busy        <= busyNext;
         frame_done  <= doneNext;
         timeout_err <= errNext;
         toCnt       <= toNext;
         shiftReg    <= shiftNext;
         bitCnt      <= bitNext;
         sending     <= sendingNext;
      end
   end

   // Shift register refills with ones so the stop bit falls out naturally.
   always_comb begin
      stateNext   = state;
      addrNext    = addr_lcs;
      reqNext     = req;
      txdNext     = txd;
      busyNext    = busy;
      doneNext    = 1'b0;
      errNext     = timeout_err;
      toNext      = toCnt;
      shiftNext   = shiftReg;
      bitNext     = bitCnt;
      sendingNext = sending;
      case (state)
         IDLE: begin
            if (start && !frame_done) begin
               addrNext  = '0;
               busyNext  = 1'b1;
               errNext   = 1'b0;
               stateNext = ISSUE;
            end
         end
         ISSUE: begin
            if (!ackS) begin
               reqNext   = 1'b1;
               toNext    = '0;
               stateNext = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (ackS) begin
               toNext    = '0;
               stateNext = WAIT_REL;
            end else if (toCnt == ToLast) begin
               reqNext     = 1'b0;
               errNext     = 1'b1;
               shiftNext   = 8'hFF;
               sendingNext = 1'b0;
               stateNext   = SEND;
            end else begin
               toNext = toCnt + 1'b1;
            end
         end
         WAIT_REL: begin
            if (!ackS) begin
               shiftNext   = data_in;
               reqNext     = 1'b0;
               sendingNext = 1'b0;
               stateNext   = SEND;
            end else if (toCnt == ToLast) begin
               reqNext     = 1'b0;
               errNext     = 1'b1;
               shiftNext   = 8'hFF;
               sendingNext = 1'b0;
               stateNext   = SEND;
            end else begin
               toNext = toCnt + 1'b1;
            end
         end
         SEND: begin
            if (tick) begin
               if (!sending) begin
                  txdNext     = 1'b0;
                  bitNext     = '0;
                  sendingNext = 1'b1;
               end else if (bitCnt == 4'd9) begin
                  sendingNext = 1'b0;
                  stateNext   = NEXT;
               end else begin
                  txdNext   = shiftReg[0];
                  shiftNext = {1'b1, shiftReg[7:1]};
                  bitNext   = bitCnt + 1'b1;
               end
            end
         end
         NEXT: begin
            if (addr_lcs == AddrLast) begin
               doneNext  = 1'b1;
               busyNext  = 1'b0;
               addrNext  = '0;
               stateNext = IDLE;
            end else begin
               addrNext  = addr_lcs + 1'b1;
               stateNext = ISSUE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

endmodule
